// File: rtl/ack_bus_pkg.sv
// ---------------------------------------------------------------------------
// ack_bus_pkg
// Shared definitions for the ack-bus round-robin scheduler.
//   - Source IDs used on winner_source_id (mem, sha, aes, ctrl).
//   - Scheduler state encoding (IDLE / GRANT / RELEASE).
//   - Common source-ID type used by the arbiter and the scheduler.
// No ports; imported by rr_pick4 and ack_bus_rr_scheduler.
// ---------------------------------------------------------------------------
package ack_bus_pkg;

    localparam int unsigned NUM_SRC = 4;

    typedef logic [1:0] src_id_t;

    localparam src_id_t SRC_MEM  = 2'd0;
    localparam src_id_t SRC_SHA  = 2'd1;
    localparam src_id_t SRC_AES  = 2'd2;
    localparam src_id_t SRC_CTRL = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Purely combinational 4-way rotating-priority picker. Starting at i_ptr and
// moving upward modulo 4, the first requester found wins.
// Ports:
//   i_req   [3:0]  request vector, bit n = source ID n
//   i_ptr   [1:0]  ID that currently has the highest priority
//   o_valid        at least one request is present
//   o_idx   [1:0]  winning source ID (equals i_ptr when o_valid is 0)
// ---------------------------------------------------------------------------
module rr_pick4
    import ack_bus_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  src_id_t            i_ptr,
    output logic               o_valid,
    output src_id_t            o_idx
);

    // Walk the candidates from lowest priority to highest so the last hit,
    // which is the one closest to i_ptr, is the value left in o_idx.
    always_comb begin
        src_id_t w_cand;
        o_valid = 1'b0;
        o_idx   = i_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_cand = i_ptr + src_id_t'(k);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/ack_bus_rr_scheduler.sv
// ---------------------------------------------------------------------------
// ack_bus_rr_scheduler
// Registered round-robin arbiter for the shared ack bus. One requester is
// granted at a time; the grant is held while the winner keeps requesting, up
// to HOLD_MAX cycles (0 = unlimited), and one dead cycle separates grants.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_mem/sha/aes/ctrl     requests from the four sources
//   ack_ready_to_*           one-hot registered grants
//   winner_source_id [1:0]   current or most recent winner (sticky)
//   ack_event                one-cycle pulse on the first cycle of a grant
//   hold_timeout             one-cycle pulse when HOLD_MAX revokes a grant
//   busy                     high while a grant is active
// ---------------------------------------------------------------------------
module ack_bus_rr_scheduler
    import ack_bus_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_mem,
    input  logic       req_sha,
    input  logic       req_aes,
    input  logic       req_ctrl,
    output logic       ack_ready_to_mem,
    output logic       ack_ready_to_sha,
    output logic       ack_ready_to_aes,
    output logic       ack_ready_to_ctrl,
    output logic [1:0] winner_source_id,
    output logic       ack_event,
    output logic       hold_timeout,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    sched_state_t        r_state;
    src_id_t             r_rrPtr;
    logic [CNT_W-1:0]    r_holdCnt;
    logic [NUM_SRC-1:0]  r_ackReady;
    src_id_t             r_winner;
    logic                r_ackEvent;
    logic                r_holdTimeout;
    logic                r_busy;

    logic [NUM_SRC-1:0]  w_req;
    logic                w_pickValid;
    src_id_t             w_pickIdx;
    logic                w_winReq;
    logic                w_limitHit;

    assign w_req      = {req_ctrl, req_aes, req_sha, req_mem};
    assign w_winReq   = w_req[r_winner];
    assign w_limitHit = (HOLD_MAX != 0) && (r_holdCnt == HOLD_LIM);

    rr_pick4 u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rrPtr),
        .o_valid (w_pickValid),
        .o_idx   (w_pickIdx)
    );

    // Scheduler FSM with all outputs registered. IDLE and RELEASE share the
    // same arbitration step, so a request seen in the dead cycle starts the
    // next grant on the closing edge of that cycle. Leaving GRANT moves the
    // pointer past the winner, which is what pushes a timed-out source to
    // the back of the rotation. A drop of the winner's request always counts
    // as a normal release, even on the edge where the limit is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rrPtr       <= SRC_MEM;
            r_holdCnt     <= '0;
            r_ackReady    <= '0;
            r_winner      <= SRC_MEM;
            r_ackEvent    <= 1'b0;
            r_holdTimeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE, RELEASE: begin
                    r_holdTimeout <= 1'b0;
                    if (w_pickValid) begin
                        r_state    <= GRANT;
                        r_ackReady <= NUM_SRC'(1) << w_pickIdx;
                        r_winner   <= w_pickIdx;
                        r_ackEvent <= 1'b1;
                        r_holdCnt  <= CNT_W'(1);
                        r_busy     <= 1'b1;
                    end else begin
                        r_state    <= IDLE;
                        r_ackReady <= '0;
                        r_ackEvent <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                GRANT: begin
                    r_ackEvent <= 1'b0;
                    if (!w_winReq || w_limitHit) begin
                        r_state       <= RELEASE;
                        r_ackReady    <= '0;
                        r_busy        <= 1'b0;
                        r_rrPtr       <= r_winner + src_id_t'(1);
                        r_holdTimeout <= w_winReq;
                    end else begin
                        r_holdTimeout <= 1'b0;
                        if (r_holdCnt != '1) begin
                            r_holdCnt <= r_holdCnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ackReady <= '0;
                    r_ackEvent <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign ack_ready_to_mem  = r_ackReady[SRC_MEM];
    assign ack_ready_to_sha  = r_ackReady[SRC_SHA];
    assign ack_ready_to_aes  = r_ackReady[SRC_AES];
    assign ack_ready_to_ctrl = r_ackReady[SRC_CTRL];
    assign winner_source_id  = r_winner;
    assign ack_event         = r_ackEvent;
    assign hold_timeout      = r_holdTimeout;
    assign busy              = r_busy;

endmodule

// File: doc/ack_bus_rr_scheduler.md
Name: ack_bus_rr_scheduler

Overview:
Registered, fair arbiter for the shared ack bus between the four requesters: mem, sha, aes and ctrl.
- Grants one requester at a time using a rotating (round-robin) priority pointer.
- The grant is held while the winner keeps its request asserted, up to a programmable hold limit.
- A single dead cycle separates consecutive grants.
- It replaces the combinational ack-bus arbitration path and drives the same ack_ready_to_* / winner_source_id / ack_event signals.

Parameters:
- HOLD_MAX, 16: maximum consecutive grant cycles per winner. 0 = unlimited.
- CNT_W, 5: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_mem  in  1  request from mem.
- req_sha  in  1  request from sha.
- req_aes  in  1  request from aes.
- req_ctrl  in  1  request from ctrl.
- ack_ready_to_mem  out  1  grant to mem (registered).
- ack_ready_to_sha  out  1  grant to sha (registered).
- ack_ready_to_aes  out  1  grant to aes (registered).
- ack_ready_to_ctrl  out  1  grant to ctrl (registered).
- winner_source_id  out  2  ID of current or last winner: mem=0, sha=1, aes=2, ctrl=3.
- ack_event  out  1  one-cycle pulse on the first cycle of each new grant.
- hold_timeout  out  1  one-cycle pulse when a grant is revoked by HOLD_MAX.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - All ack_ready_to_* = 0, winner_source_id = 0, ack_event = 0, hold_timeout = 0, busy = 0.
  - State = IDLE, rr_ptr = 0, hold_cnt = 0.
  - Reset wins over every other event, including mid-grant; the grant drops on the same edge.
- Arbitration function: scan IDs starting at rr_ptr upward, modulo 4. The first one with req=1 wins.
- IDLE:
  - If any req=1 at an edge: state becomes GRANT at that edge.
  - On that edge: the winner's ack_ready=1, winner_source_id=winner, ack_event=1, hold_cnt=1.
  - Latency from req sampled to grant visible: 1 cycle.
  - No req: stay in IDLE.
- GRANT:
  - Exactly one ack_ready is high (one-hot); busy=1; ack_event=0 after the first cycle.
  - Requests from non-winners are ignored; there is no preemption by priority.
  - Exit to RELEASE at the edge where either:
    - the winner's req=0, or
    - HOLD_MAX != 0 and hold_cnt == HOLD_MAX.
  - Otherwise hold_cnt increments, saturating at its maximum value.
  - On exit: all ack_ready = 0 and rr_ptr = winner + 1 (mod 4).
  - If exit was caused by the limit (winner's req still 1): hold_timeout = 1 for one cycle.
  - If the winner's req drops on the same edge the limit is reached: treat as a normal release, hold_timeout = 0.
- RELEASE:
  - One dead cycle with all ack_ready = 0.
  - At its closing edge, arbitrate with the updated rr_ptr.
  - Any req: go to GRANT, with the same outputs as from IDLE.
  - No req: go to IDLE.
  - Back-to-back grants are therefore separated by exactly one low cycle.
- Sticky and timing rules:
  - winner_source_id holds the last winner through RELEASE and IDLE.
  - It changes only on a new grant.
  - ack_event and the matching ack_ready rise on the same edge.
- A timed-out winner still requesting loses priority to every other requester and is served again only after a full rotation, if nobody else is requesting.
- All outputs come directly from flops; there is no combinational path from req to any output.

Decomposition:
- Package ack_bus_pkg holds:
  - source ID constants SRC_MEM=2'd0, SRC_SHA=2'd1, SRC_AES=2'd2, SRC_CTRL=2'd3;
  - state encoding IDLE / GRANT / RELEASE (2-bit).
- Sub-module rr_pick4 is purely combinational:
  - inputs: req vector [3:0] and ptr [1:0];
  - outputs: valid and idx [1:0];
  - used in both IDLE and RELEASE arbitration.
- The remainder (FSM, hold counter, output registers) lives in ack_bus_rr_scheduler.

Test Plan:
- Reset, then req_sha=1 alone held 5 cycles then dropped:
  - ack_ready_to_sha=1 one cycle after req, for 5 cycles;
  - winner_source_id=1; ack_event pulses once;
  - after drop: 1 low cycle, then IDLE with winner_source_id still 1.
- All four reqs held high continuously, HOLD_MAX=4:
  - grants rotate mem→sha→aes→ctrl→mem, 4 cycles each with 1 gap;
  - hold_timeout pulses at every rotation;
  - ack_event pulses 4 times per rotation.
- req_aes held high alone, HOLD_MAX=3:
  - grant for 3 cycles, hold_timeout=1, one gap cycle, then re-granted to aes with ack_event=1.
- HOLD_MAX=0 (unlimited), req_mem held 40 cycles while req_ctrl=1:
  - mem keeps its grant for all 40 cycles, with no timeout;
  - ctrl is granted after the one-cycle gap.
- rst=1 asserted on the 3rd grant cycle of ctrl:
  - next edge: all outputs 0 and state IDLE;
  - with all reqs still high after rst deasserts, mem (ptr=0) wins first.
- Winner req drops on the same edge hold_cnt reaches HOLD_MAX:
  - hold_timeout stays 0; normal release; rr_ptr advances.
